// File: rtl/musa_control_fsm.sv
// MUSA multicycle control unit: latches the opcode of each accepted instruction,
// sequences FETCH/DECODE/EXEC/MEM/WB/HALT, and drives registered datapath controls.
module musa_control_fsm #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  instr_valid,
    input  logic                  mem_ready,
    output logic                  reg_dst,
    output logic                  mem_read,
    output logic                  mem_to_reg,
    output logic [2:0]            alu_op,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            data_a_s,
    output logic [1:0]            data_b_s,
    output logic [2:0]            pc_src,
    output logic                  push,
    output logic                  pop,
    output logic                  ir_load,
    output logic                  pc_write,
    output logic                  halted,
    output logic                  illegal_op
);

    // Opcode encodings (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_CMP   = 6'h10;
    localparam logic [5:0] OP_BRFL  = 6'h11;
    localparam logic [5:0] OP_JPC   = 6'h12;
    localparam logic [5:0] OP_JR    = 6'h13;
    localparam logic [5:0] OP_CALL  = 6'h14;
    localparam logic [5:0] OP_RET   = 6'h15;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [2:0] PC_SEQ = 3'b010;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e      r_state, w_state_nxt;
    // Only the opcode drives sequencing; R-type functs (incl. MULT/DIV) share one ALU class.
    logic [5:0]  r_opcode;
    logic [5:0]  w_in_op;
    logic        w_unused;

    logic        r_reg_dst, r_mem_read, r_mem_to_reg, r_mem_write, r_reg_write;
    logic        r_push, r_pop, r_ir_load, r_pc_write, r_halted, r_illegal_op;
    logic [2:0]  r_alu_op, r_pc_src;
    logic [1:0]  r_a_s, r_b_s;

    logic        w_reg_dst, w_mem_read, w_mem_to_reg, w_mem_write, w_reg_write;
    logic        w_push, w_pop, w_ir_load, w_pc_write, w_halted, w_illegal_op;
    logic [2:0]  w_alu_op, w_pc_src;
    logic [1:0]  w_a_s, w_b_s;

    assign w_in_op  = instruction[31:26];
    assign w_unused = ^instruction;

    function automatic logic f_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_CMP, OP_BRFL, OP_JPC,
            OP_JR, OP_CALL, OP_RET, OP_LW, OP_SW, OP_HALT: f_legal = 1'b1;
            default:                                       f_legal = 1'b0;
        endcase
    endfunction

    // State and opcode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StFetch;
            r_opcode <= 6'h00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StFetch && instr_valid) r_opcode <= w_in_op;
        end
    end

    // Next-state sequencing
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StFetch:  if (instr_valid) w_state_nxt = StDecode;
            StDecode: w_state_nxt = f_legal(r_opcode) ? StExec : StFetch;
            StExec: begin
                case (r_opcode)
                    OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: w_state_nxt = StWb;
                    OP_LW, OP_SW:                                w_state_nxt = StMem;
                    OP_HALT:                                     w_state_nxt = StHalt;
                    default:                                     w_state_nxt = StFetch;
                endcase
            end
            StMem:    if (mem_ready) w_state_nxt = (r_opcode == OP_LW) ? StWb : StFetch;
            StWb:     w_state_nxt = StFetch;
            StHalt:   w_state_nxt = StHalt;
            default:  w_state_nxt = StFetch;
        endcase
    end

    // Next value of every output, so each one is registered into the state it belongs to.
    // Strobes default low; selectors hold unless the instruction is entering EXEC or FETCH.
    always_comb begin
        w_reg_dst    = r_reg_dst;
        w_mem_to_reg = r_mem_to_reg;
        w_alu_op     = r_alu_op;
        w_a_s        = r_a_s;
        w_b_s        = r_b_s;
        w_pc_src     = r_pc_src;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_ir_load    = 1'b0;
        w_pc_write   = 1'b0;
        w_halted     = 1'b0;
        w_illegal_op = 1'b0;
        unique case (r_state)
            StFetch: begin
                if (instr_valid) begin
                    w_ir_load = 1'b1;
                    // Illegal opcodes are flagged in DECODE, which is decoded from the input here
                    if (!f_legal(w_in_op)) begin
                        w_illegal_op = 1'b1;
                        w_pc_write   = 1'b1;
                        w_pc_src     = PC_SEQ;
                    end
                end
            end
            StDecode: begin
                w_reg_dst    = 1'b0;
                w_mem_to_reg = 1'b0;
                w_alu_op     = 3'b000;
                w_a_s        = 2'b00;
                w_b_s        = 2'b00;
                case (r_opcode)
                    OP_RTYPE: begin
                        w_reg_dst = 1'b1; w_alu_op = 3'b010; w_a_s = 2'b10; w_b_s = 2'b01;
                        w_pc_src  = PC_SEQ;
                    end
                    OP_ADDI: begin w_alu_op = 3'b000; w_a_s = 2'b10; w_pc_src = PC_SEQ; end
                    OP_SUBI: begin w_alu_op = 3'b001; w_a_s = 2'b10; w_pc_src = PC_SEQ; end
                    OP_ANDI: begin w_alu_op = 3'b011; w_a_s = 2'b10; w_pc_src = PC_SEQ; end
                    OP_ORI:  begin w_alu_op = 3'b100; w_a_s = 2'b10; w_pc_src = PC_SEQ; end
                    OP_LW:   begin w_a_s = 2'b10; w_mem_to_reg = 1'b1; w_pc_src = PC_SEQ; end
                    OP_SW:   begin w_a_s = 2'b10; w_pc_src = PC_SEQ; end
                    OP_CMP: begin
                        w_alu_op = 3'b110; w_a_s = 2'b10; w_b_s = 2'b01;
                        w_pc_src = PC_SEQ; w_pc_write = 1'b1;
                    end
                    OP_BRFL: begin
                        w_alu_op = 3'b101; w_a_s = 2'b10; w_pc_src = 3'b001; w_pc_write = 1'b1;
                    end
                    OP_JPC:  begin w_b_s = 2'b10; w_pc_src = 3'b011; w_pc_write = 1'b1; end
                    OP_JR:   begin w_pc_src = 3'b001; w_pc_write = 1'b1; end
                    OP_CALL: begin w_push = 1'b1; w_pc_src = 3'b001; w_pc_write = 1'b1; end
                    OP_RET:  begin w_pop = 1'b1; w_pc_src = 3'b000; w_pc_write = 1'b1; end
                    OP_HALT: w_pc_src = 3'b100;
                    default: ;
                endcase
            end
            StExec: begin
                unique case (w_state_nxt)
                    StWb: begin
                        w_reg_write = 1'b1;
                        w_pc_write  = 1'b1;
                    end
                    StMem: begin
                        w_mem_read  = (r_opcode == OP_LW);
                        w_mem_write = (r_opcode == OP_SW);
                    end
                    StHalt: w_halted = 1'b1;
                    default: begin
                        w_reg_dst    = 1'b0;
                        w_mem_to_reg = 1'b0;
                        w_alu_op     = 3'b000;
                        w_a_s        = 2'b00;
                        w_b_s        = 2'b00;
                    end
                endcase
            end
            StMem: begin
                if (!mem_ready) begin
                    w_mem_read  = (r_opcode == OP_LW);
                    w_mem_write = (r_opcode == OP_SW);
                end else if (r_opcode == OP_LW) begin
                    w_reg_write = 1'b1;
                    w_pc_write  = 1'b1;
                end else begin
                    // SW completes: the PC update lands in the first FETCH cycle
                    w_pc_write   = 1'b1;
                    w_reg_dst    = 1'b0;
                    w_mem_to_reg = 1'b0;
                    w_alu_op     = 3'b000;
                    w_a_s        = 2'b00;
                    w_b_s        = 2'b00;
                end
            end
            StWb: begin
                w_reg_dst    = 1'b0;
                w_mem_to_reg = 1'b0;
                w_alu_op     = 3'b000;
                w_a_s        = 2'b00;
                w_b_s        = 2'b00;
            end
            StHalt:  w_halted = 1'b1;
            default: ;
        endcase
    end

    // Output registers; async reset drops every strobe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_dst    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= 3'b000;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_a_s        <= 2'b00;
            r_b_s        <= 2'b00;
            r_pc_src     <= PC_SEQ;
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_ir_load    <= 1'b0;
            r_pc_write   <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_reg_dst    <= w_reg_dst;
            r_mem_read   <= w_mem_read;
            r_mem_to_reg <= w_mem_to_reg;
            r_alu_op     <= w_alu_op;
            r_mem_write  <= w_mem_write;
            r_reg_write  <= w_reg_write;
            r_a_s        <= w_a_s;
            r_b_s        <= w_b_s;
            r_pc_src     <= w_pc_src;
            r_push       <= w_push;
            r_pop        <= w_pop;
            r_ir_load    <= w_ir_load;
            r_pc_write   <= w_pc_write;
            r_halted     <= w_halted;
            r_illegal_op <= w_illegal_op;
        end
    end

    assign reg_dst    = r_reg_dst;
    assign mem_read   = r_mem_read;
    assign mem_to_reg = r_mem_to_reg;
    assign alu_op     = r_alu_op;
    assign mem_write  = r_mem_write;
    assign reg_write  = r_reg_write;
    assign data_a_s   = r_a_s;
    assign data_b_s   = r_b_s;
    assign pc_src     = r_pc_src;
    assign push       = r_push;
    assign pop        = r_pop;
    assign ir_load    = r_ir_load;
    assign pc_write   = r_pc_write;
    assign halted     = r_halted;
    assign illegal_op = r_illegal_op;

endmodule

// File: tb/tb_musa_control_fsm.sv
// Directed bench for musa_control_fsm: vector table for single-pass instructions plus
// hand sequences for reset, memory waits, HALT and illegal opcodes.
module tb_musa_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        mem_ready;
    logic        reg_dst, mem_read, mem_to_reg, mem_write, reg_write;
    logic        push, pop, ir_load, pc_write, halted, illegal_op;
    logic [2:0]  alu_op, pc_src;
    logic [1:0]  data_a_s, data_b_s;

    int total = 0;
    int bad   = 0;

    musa_control_fsm #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .reg_dst     (reg_dst),
        .mem_read    (mem_read),
        .mem_to_reg  (mem_to_reg),
        .alu_op      (alu_op),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .data_a_s    (data_a_s),
        .data_b_s    (data_b_s),
        .pc_src      (pc_src),
        .push        (push),
        .pop         (pop),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .halted      (halted),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs, packed in a fixed order
    logic [20:0] obs;
    assign obs = {reg_dst, mem_read, mem_to_reg, alu_op, mem_write, reg_write, data_a_s,
                  data_b_s, pc_src, push, pop, ir_load, pc_write, halted, illegal_op};

    function automatic logic [20:0] ev(input logic rd, input logic mr, input logic m2r,
                                       input logic [2:0] alu, input logic mw, input logic rw,
                                       input logic [1:0] as_, input logic [1:0] bs,
                                       input logic [2:0] pcs, input logic ps, input logic pp,
                                       input logic irl, input logic pcw, input logic hl,
                                       input logic ill);
        return {rd, mr, m2r, alu, mw, rw, as_, bs, pcs, ps, pp, irl, pcw, hl, ill};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] funct);
        return {op, 20'h0, funct};
    endfunction

    task automatic check(input string nm, input logic [20:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        rd;
        logic [2:0]  alu;
        logic [1:0]  as_;
        logic [1:0]  bs;
        logic [2:0]  pcs;
        logic        ps;
        logic        pp;
        logic        pcw;
        logic        wb;
    } vec_t;

    vec_t        tbl[11];
    logic [2:0]  prev_pcs;
    logic [20:0] idle_seq;

    initial begin
        tbl[0]  = '{"add",  32'h0000_0020, 1'b1, 3'b010, 2'b10, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{"addi", 32'h2000_0000, 1'b0, 3'b000, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{"subi", 32'h2400_0000, 1'b0, 3'b001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{"andi", 32'h3000_0000, 1'b0, 3'b011, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{"ori",  32'h3400_0000, 1'b0, 3'b100, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{"cmp",  32'h4000_0000, 1'b0, 3'b110, 2'b10, 2'b01, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{"brfl", 32'h4400_0000, 1'b0, 3'b101, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{"jpc",  32'h4800_0000, 1'b0, 3'b000, 2'b00, 2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{"jr",   32'h4C00_0000, 1'b0, 3'b000, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{"call", 32'h5000_0000, 1'b0, 3'b000, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{"ret",  32'h5400_0000, 1'b0, 3'b000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};

        idle_seq = ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0);

        // Reset with instr_valid held high
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        mem_ready   = 1'b0;
        instruction = mk(6'h00, 6'h20);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", idle_seq);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("reset_ir_load", ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0, 1, 0, 0, 0));
        instr_valid = 1'b0;
        step();
        check("add_exec", ev(1, 0, 0, 3'b010, 0, 0, 2'b10, 2'b01, 3'b010, 0, 0, 0, 0, 0, 0));
        step();
        check("add_wb", ev(1, 0, 0, 3'b010, 0, 1, 2'b10, 2'b01, 3'b010, 0, 0, 0, 1, 0, 0));
        step();
        check("add_fetch", idle_seq);

        // Table of instructions that never enter MEM or HALT
        prev_pcs = 3'b010;
        for (int i = 0; i < 11; i++) begin
            instruction = tbl[i].instr;
            instr_valid = 1'b1;
            step();
            check({tbl[i].name, "_decode"},
                  ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, prev_pcs, 0, 0, 1, 0, 0, 0));
            instr_valid = 1'b0;
            step();
            check({tbl[i].name, "_exec"},
                  ev(tbl[i].rd, 0, 0, tbl[i].alu, 0, 0, tbl[i].as_, tbl[i].bs, tbl[i].pcs,
                     tbl[i].ps, tbl[i].pp, 0, tbl[i].pcw, 0, 0));
            if (tbl[i].wb) begin
                step();
                check({tbl[i].name, "_wb"},
                      ev(tbl[i].rd, 0, 0, tbl[i].alu, 0, 1, tbl[i].as_, tbl[i].bs, tbl[i].pcs,
                         0, 0, 0, 1, 0, 0));
            end
            step();
            check({tbl[i].name, "_fetch"},
                  ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, tbl[i].pcs, 0, 0, 0, 0, 0, 0));
            prev_pcs = tbl[i].pcs;
        end

        // LW with mem_ready arriving on the third MEM cycle
        instruction = mk(6'h23, 6'h00);
        instr_valid = 1'b1;
        mem_ready   = 1'b0;
        step();
        check("lw_decode", ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, prev_pcs, 0, 0, 1, 0, 0, 0));
        instr_valid = 1'b0;
        step();
        check("lw_exec", ev(0, 0, 1, 3'b000, 0, 0, 2'b10, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("lw_mem%0d", c), ev(0, 1, 1, 3'b000, 0, 0, 2'b10, 2'b00, 3'b010,
                                                0, 0, 0, 0, 0, 0));
        end
        mem_ready = 1'b1;
        step();
        // Seventh cycle counting the accept cycle
        check("lw_wb", ev(0, 0, 1, 3'b000, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0, 0, 1, 0, 0));
        mem_ready = 1'b0;
        step();
        check("lw_fetch", idle_seq);

        // SW with memory ready immediately
        instruction = mk(6'h2B, 6'h00);
        instr_valid = 1'b1;
        mem_ready   = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        check("sw_exec", ev(0, 0, 0, 3'b000, 0, 0, 2'b10, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0));
        step();
        check("sw_mem", ev(0, 0, 0, 3'b000, 1, 0, 2'b10, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0));
        step();
        check("sw_done", ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0, 1, 0, 0));
        step();
        check("sw_idle", idle_seq);

        // Illegal opcode
        instruction = mk(6'h3E, 6'h00);
        instr_valid = 1'b1;
        step();
        check("ill_decode", ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0, 1, 1, 0, 1));
        instr_valid = 1'b0;
        step();
        check("ill_fetch", idle_seq);
        step();
        check("ill_quiet", idle_seq);

        // Reset asserted while SW waits in MEM
        instruction = mk(6'h2B, 6'h00);
        instr_valid = 1'b1;
        mem_ready   = 1'b0;
        step();
        instr_valid = 1'b0;
        step();
        step();
        check("sw_wait_mem", ev(0, 0, 0, 3'b000, 1, 0, 2'b10, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_async_reset", idle_seq);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_idle", idle_seq);

        // HALT ignores instr_valid until reset
        instruction = mk(6'h3F, 6'h00);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        check("halt_exec", ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 3'b100, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 6; c++) begin
            instr_valid = ~instr_valid;
            step();
            check($sformatf("halt_hold%0d", c), ev(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 3'b100,
                                                   0, 0, 0, 0, 1, 0));
        end
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("halt_reset", idle_seq);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("halt_reset_idle", idle_seq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
